// File: rtl/maple_tx.sv
`default_nettype none
// ============================================================================
//  Module      : maple_tx
//  Description : Maple bus frame transmitter. Serialises upstream bytes onto
//                SDCKA/SDCKB with start pattern, XOR CRC and end pattern.
//  Revision    : 1.0 - initial release
// ============================================================================
module maple_tx #(
    parameter int CLK_DIV    = 4,
    parameter int APPEND_CRC = 1,
    parameter int TIMEOUT    = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_active,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       sdcka_o,
    output logic       sdckb_o,
    output logic       sdck_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_abort
);

    localparam int c_div_w   = $clog2(CLK_DIV + 1);
    localparam int c_stall_w = $clog2(TIMEOUT + 1);
    localparam logic [c_div_w-1:0]   c_div_last   = c_div_w'(CLK_DIV - 1);
    localparam logic [c_div_w-1:0]   c_div_pre    = c_div_w'(CLK_DIV);
    localparam logic [c_stall_w-1:0] c_stall_last = c_stall_w'(TIMEOUT - 1);

    localparam logic [2:0] c_idle  = 3'd0;
    localparam logic [2:0] c_pre   = 3'd1;
    localparam logic [2:0] c_start = 3'd2;
    localparam logic [2:0] c_bit   = 3'd3;
    localparam logic [2:0] c_next  = 3'd4;
    localparam logic [2:0] c_crc   = 3'd5;
    localparam logic [2:0] c_end   = 3'd6;
    localparam logic [2:0] c_post  = 3'd7;

    logic [2:0]           r_state,  w_state;
    logic [3:0]           r_step,   w_step;
    logic [c_div_w-1:0]   r_div,    w_div;
    logic [c_stall_w-1:0] r_stall,  w_stall;
    logic [7:0]           r_shreg,  w_shreg;
    logic [7:0]           r_crc,    w_crc;
    logic                 r_last,   w_last;
    logic                 r_crc_ph, w_crc_ph;
    logic                 r_abort,  w_abort;
    logic                 r_busy,   w_busy;
    logic                 r_done,   w_done;
    logic                 r_abt_p,  w_abt_p;
    logic                 r_a,      w_a;
    logic                 r_b,      w_b;
    logic                 r_oe;
    logic                 w_tick;
    logic                 w_accept;
    logic [2:0]           w_bit_idx;
    logic                 w_sdat;

    assign tx_ready = reset & (((r_state == c_idle) & ~rx_active) | (r_state == c_next));
    assign w_accept = tx_valid & tx_ready;
    // PRE absorbs the byte-load cycle, so it runs one clk longer than a tick
    assign w_tick   = (r_div == ((r_state == c_pre) ? c_div_pre : c_div_last));

    always_comb begin
        w_state  = r_state;
        w_step   = r_step;
        w_div    = w_tick ? '0 : r_div + 1'b1;
        w_stall  = r_stall;
        w_shreg  = r_shreg;
        w_crc    = r_crc;
        w_last   = r_last;
        w_crc_ph = r_crc_ph;
        w_abort  = r_abort;
        w_busy   = r_busy;
        w_done   = 1'b0;
        w_abt_p  = 1'b0;
        case (r_state)
            c_idle: begin
                w_div = '0;
                if (w_accept) begin
                    w_state  = c_pre;
                    w_shreg  = tx_data;
                    w_crc    = tx_data;
                    w_last   = tx_last;
                    w_crc_ph = 1'b0;
                    w_abort  = 1'b0;
                    w_busy   = 1'b1;
                end
            end
            c_pre: if (w_tick) begin
                w_state = c_start;
                w_step  = '0;
            end
            c_start: if (w_tick) begin
                if (r_step == 4'd9) begin
                    w_state = c_bit;
                    w_step  = '0;
                end else begin
                    w_step = r_step + 4'd1;
                end
            end
            c_bit: if (w_tick) begin
                if (r_step == 4'd15) begin
                    w_step  = '0;
                    w_stall = '0;
                    if (!r_last)
                        w_state = c_next;
                    else if ((APPEND_CRC != 0) && !r_crc_ph)
                        w_state = c_crc;
                    else
                        w_state = c_end;
                end else begin
                    w_step = r_step + 4'd1;
                end
            end
            c_next: begin
                w_div = '0;
                if (w_accept) begin
                    w_state = c_bit;
                    w_step  = '0;
                    w_shreg = tx_data;
                    w_crc   = r_crc ^ tx_data;
                    w_last  = tx_last;
                end else if (r_stall == c_stall_last) begin
                    w_state = c_end;
                    w_step  = '0;
                    w_abort = 1'b1;
                end else begin
                    w_stall = r_stall + 1'b1;
                end
            end
            c_crc: begin
                w_div    = '0;
                w_state  = c_bit;
                w_step   = '0;
                w_shreg  = r_crc;
                w_last   = 1'b1;
                w_crc_ph = 1'b1;
            end
            c_end: if (w_tick) begin
                if (r_step == 4'd5) begin
                    w_state = c_post;
                    w_step  = '0;
                end else begin
                    w_step = r_step + 4'd1;
                end
            end
            c_post: if (w_tick) begin
                w_state = c_idle;
                w_busy  = 1'b0;
                w_done  = ~r_abort;
                w_abt_p = r_abort;
            end
            default: w_state = c_idle;
        endcase
    end

    // Line levels are decoded from the next state so the pads change on state edges
    assign w_bit_idx = 3'd7 - w_step[3:1];
    assign w_sdat    = w_shreg[w_bit_idx];

    always_comb begin
        w_a = 1'b1;
        w_b = 1'b1;
        case (w_state)
            c_start: begin
                if (w_step == 4'd9) begin
                    w_a = 1'b1;
                    w_b = 1'b1;
                end else begin
                    w_a = 1'b0;
                    w_b = ~w_step[0];
                end
            end
            c_bit: begin
                if (!w_step[1]) begin
                    w_a = ~w_step[0];
                    w_b = w_sdat;
                end else begin
                    w_a = w_sdat;
                    w_b = ~w_step[0];
                end
            end
            c_next, c_crc: begin
                w_a = r_a;
                w_b = r_b;
            end
            c_end: begin
                if (w_step == 4'd5) begin
                    w_a = 1'b1;
                    w_b = 1'b1;
                end else begin
                    w_a = ~w_step[0];
                    w_b = 1'b0;
                end
            end
            default: begin
                w_a = 1'b1;
                w_b = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= c_idle;
            r_step   <= '0;
            r_div    <= '0;
            r_stall  <= '0;
            r_shreg  <= '0;
            r_crc    <= '0;
            r_last   <= 1'b0;
            r_crc_ph <= 1'b0;
            r_abort  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_abt_p  <= 1'b0;
            r_a      <= 1'b1;
            r_b      <= 1'b1;
            r_oe     <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_step   <= w_step;
            r_div    <= w_div;
            r_stall  <= w_stall;
            r_shreg  <= w_shreg;
            r_crc    <= w_crc;
            r_last   <= w_last;
            r_crc_ph <= w_crc_ph;
            r_abort  <= w_abort;
            r_busy   <= w_busy;
            r_done   <= w_done;
            r_abt_p  <= w_abt_p;
            r_a      <= w_a;
            r_b      <= w_b;
            r_oe     <= (w_state != c_idle);
        end
    end

    assign sdcka_o  = r_a;
    assign sdckb_o  = r_b;
    assign sdck_oe  = r_oe;
    assign busy     = r_busy;
    assign tx_done  = r_done;
    assign tx_abort = r_abt_p;

endmodule
`default_nettype wire
